// File: rtl/mdu_seq.sv
// Shared ALU operation encoding, followed by the mdu_seq sequencer that
// drives an external combinational ALU to perform unsigned MUL and DIV
// one bit per step.
package alu_pkg;
  typedef enum logic [1:0] {
    ALU_NOP = 2'd0,
    ALU_ADD = 2'd1,
    ALU_SUB = 2'd2,
    ALU_SLT = 2'd3
  } e_alu_op;
endpackage

module mdu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_div,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_dbz,
  output e_alu_op          alu_op,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_CMP,
    S_DIV_SUB,
    S_DONE
  } e_state;

  e_state           r_state;
  e_state           w_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rs;
  logic             r_ge;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_rspLo;
  logic             r_dbz;

  logic             w_carry;
  logic             w_lastStep;
  logic [WIDTH-1:0] w_rs;
  logic             w_msb;
  logic [WIDTH-1:0] w_mulAcc;
  logic [WIDTH-1:0] w_mulLo;
  logic [WIDTH-1:0] w_divQ;

  // Shift-add carry is recovered from unsigned wrap; the division partial
  // remainder pulls the next dividend bit in, with the bit shifted out of
  // the remainder kept as an implicit ninth bit.
  assign w_carry    = (alu_result < r_acc);
  assign w_lastStep = (r_cnt == CW'(WIDTH - 1));
  assign w_rs       = {r_acc[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_msb      = r_acc[WIDTH-1];
  assign w_mulAcc   = {w_carry, alu_result[WIDTH-1:1]};
  assign w_mulLo    = {alu_result[0], r_lo[WIDTH-1:1]};
  assign w_divQ     = {r_lo[WIDTH-1:1], r_ge};

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_hi    = r_hi;
  assign rsp_lo    = r_rspLo;
  assign rsp_dbz   = r_dbz;

  // Next-state selection for the sequencer.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_div && (req_b == '0)) w_next = S_DONE;
          else if (req_div)             w_next = S_DIV_CMP;
          else                          w_next = S_MUL;
        end
      end
      S_MUL:     if (w_lastStep) w_next = S_DONE;
      S_DIV_CMP: w_next = S_DIV_SUB;
      S_DIV_SUB: w_next = w_lastStep ? S_DONE : S_DIV_CMP;
      S_DONE:    if (rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // ALU drive derived purely from registered state.
  always_comb begin
    alu_op   = ALU_NOP;
    alu_srcA = '0;
    alu_srcB = '0;
    unique case (r_state)
      S_MUL: begin
        alu_op   = ALU_ADD;
        alu_srcA = r_acc;
        alu_srcB = r_lo[0] ? r_b : '0;
      end
      S_DIV_CMP: begin
        alu_op   = ALU_SLT;
        alu_srcA = r_b;
        alu_srcB = w_rs;
      end
      S_DIV_SUB: begin
        if (r_ge) begin
          alu_op   = ALU_SUB;
          alu_srcA = r_rs;
          alu_srcB = r_b;
        end else begin
          alu_op   = ALU_NOP;
          alu_srcA = r_rs;
        end
      end
      default: begin
        alu_op   = ALU_NOP;
        alu_srcA = '0;
        alu_srcB = '0;
      end
    endcase
  end

  // State register, datapath iteration and response capture on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_rs    <= '0;
      r_ge    <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_rspLo <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_acc <= '0;
            r_lo  <= req_a;
            r_b   <= req_b;
            r_cnt <= '0;
            if (req_div && (req_b == '0)) begin
              r_hi    <= req_a;
              r_rspLo <= '1;
              r_dbz   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mulAcc;
          r_lo  <= w_mulLo;
          r_cnt <= r_cnt + CW'(1);
          if (w_lastStep) begin
            r_hi    <= w_mulAcc;
            r_rspLo <= w_mulLo;
            r_dbz   <= 1'b0;
          end
        end
        S_DIV_CMP: begin
          r_rs <= w_rs;
          r_ge <= w_msb | alu_zero;
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
        S_DIV_SUB: begin
          r_acc <= alu_result;
          r_lo  <= w_divQ;
          r_cnt <= r_cnt + CW'(1);
          if (w_lastStep) begin
            r_hi    <= alu_result;
            r_rspLo <= w_divQ;
            r_dbz   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed cases from the feature list plus
// randomized MUL/DIV traffic, compared against plain arithmetic.
module tb_mdu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         reqValid;
  logic         reqReady;
  logic         reqDiv;
  logic [W-1:0] reqA;
  logic [W-1:0] reqB;
  logic         rspValid;
  logic         rspReady;
  logic [W-1:0] rspHi;
  logic [W-1:0] rspLo;
  logic         rspDbz;
  e_alu_op      aluOp;
  logic [W-1:0] aluSrcA;
  logic [W-1:0] aluSrcB;
  logic [W-1:0] aluResult;
  logic         aluZero;

  int totalChecks = 0;
  int badChecks   = 0;

  mdu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_div    (reqDiv),
    .req_a      (reqA),
    .req_b      (reqB),
    .rsp_valid  (rspValid),
    .rsp_ready  (rspReady),
    .rsp_hi     (rspHi),
    .rsp_lo     (rspLo),
    .rsp_dbz    (rspDbz),
    .alu_op     (aluOp),
    .alu_srcA   (aluSrcA),
    .alu_srcB   (aluSrcB),
    .alu_result (aluResult),
    .alu_zero   (aluZero)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU. The compare op raises its result when the
  // candidate remainder (B) is below the divisor (A), so a zero flag means
  // the remainder is large enough to subtract.
  always_comb begin
    aluResult = '0;
    case (aluOp)
      ALU_ADD: aluResult = aluSrcA + aluSrcB;
      ALU_SUB: aluResult = aluSrcA - aluSrcB;
      ALU_SLT: aluResult = (aluSrcB < aluSrcA) ? W'(1) : W'(0);
      default: aluResult = aluSrcA;
    endcase
    aluZero = (aluResult == '0);
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one request, check latency, ALU activity and the result, hold the
  // response under backpressure for holdCycles, then retire it.
  task automatic applyStimulus(input logic isDiv, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int holdCycles);
    logic [2*W-1:0] product;
    logic [W-1:0]   expHi;
    logic [W-1:0]   expLo;
    logic           expDbz;
    int             expLat;
    int             cyc;
    int             addCnt;
    int             sltCnt;
    int             subCnt;
    int             nopCnt;
    int             onesInQ;

    if (!isDiv) begin
      product = 16'(a) * 16'(b);
      expHi   = product[2*W-1:W];
      expLo   = product[W-1:0];
      expDbz  = 1'b0;
      expLat  = W + 1;
    end else if (b == '0) begin
      expHi  = a;
      expLo  = '1;
      expDbz = 1'b1;
      expLat = 1;
    end else begin
      expHi  = a % b;
      expLo  = a / b;
      expDbz = 1'b0;
      expLat = 2 * W + 1;
    end
    onesInQ = $countones(expLo);

    @(negedge clk);
    checkOutput("req_ready idle", 32'(reqReady), 32'd1);
    reqValid = 1'b1;
    reqDiv   = isDiv;
    reqA     = a;
    reqB     = b;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    reqA     = W'($urandom);
    reqB     = W'($urandom);

    cyc = 1; addCnt = 0; sltCnt = 0; subCnt = 0; nopCnt = 0;
    while (!rspValid && cyc < 60) begin
      case (aluOp)
        ALU_ADD: addCnt++;
        ALU_SLT: sltCnt++;
        ALU_SUB: subCnt++;
        default: nopCnt++;
      endcase
      @(negedge clk);
      cyc++;
    end

    checkOutput("latency", 32'(cyc), 32'(expLat));
    if (!rspValid) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end

    if (!isDiv) begin
      checkOutput("mul add cycles", 32'(addCnt), 32'(W));
    end else if (b == '0) begin
      checkOutput("dbz alu busy cycles", 32'(addCnt + sltCnt + subCnt + nopCnt), 32'd0);
    end else begin
      checkOutput("div cmp cycles", 32'(sltCnt), 32'(W));
      checkOutput("div sub cycles", 32'(subCnt), 32'(onesInQ));
      checkOutput("div nop cycles", 32'(nopCnt), 32'(W - onesInQ));
    end
    checkOutput("rsp_hi", 32'(rspHi), 32'(expHi));
    checkOutput("rsp_lo", 32'(rspLo), 32'(expLo));
    checkOutput("rsp_dbz", 32'(rspDbz), 32'(expDbz));
    checkOutput("done alu_op", 32'(aluOp), 32'(ALU_NOP));

    for (int i = 0; i < holdCycles; i++) begin
      reqValid = (i == 0);
      reqDiv   = 1'b0;
      @(negedge clk);
      reqValid = 1'b0;
      checkOutput("hold rsp_valid", 32'(rspValid), 32'd1);
      checkOutput("hold req_ready", 32'(reqReady), 32'd0);
      checkOutput("hold rsp_hi", 32'(rspHi), 32'(expHi));
      checkOutput("hold rsp_lo", 32'(rspLo), 32'(expLo));
    end

    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("post rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("post req_ready", 32'(reqReady), 32'd1);
  endtask

  // Main sequence: reset checks, directed cases, reset abort, random traffic.
  initial begin
    logic           rDiv;
    logic [W-1:0]   rA;
    logic [W-1:0]   rB;

    rst      = 1'b1;
    reqValid = 1'b0;
    reqDiv   = 1'b0;
    reqA     = '0;
    reqB     = '0;
    rspReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset req_ready", 32'(reqReady), 32'd1);
    checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset rsp_hi", 32'(rspHi), 32'd0);
    checkOutput("reset rsp_lo", 32'(rspLo), 32'd0);
    checkOutput("reset rsp_dbz", 32'(rspDbz), 32'd0);
    checkOutput("reset alu_op", 32'(aluOp), 32'(ALU_NOP));
    checkOutput("reset alu_srcA", 32'(aluSrcA), 32'd0);
    checkOutput("reset alu_srcB", 32'(aluSrcB), 32'd0);

    applyStimulus(1'b0, 8'd200, 8'd100, 0);
    applyStimulus(1'b1, 8'd200, 8'd7,   0);
    applyStimulus(1'b1, 8'd250, 8'd130, 1);
    applyStimulus(1'b1, 8'd5,   8'd9,   0);
    applyStimulus(1'b1, 8'd55,  8'd0,   2);
    applyStimulus(1'b0, 8'd15,  8'd17,  5);

    @(negedge clk);
    reqValid = 1'b1;
    reqDiv   = 1'b0;
    reqA     = 8'd123;
    reqB     = 8'd45;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("abort req_ready", 32'(reqReady), 32'd1);
    checkOutput("abort alu_op", 32'(aluOp), 32'(ALU_NOP));
    checkOutput("abort rsp_hi", 32'(rspHi), 32'd0);
    checkOutput("abort rsp_lo", 32'(rspLo), 32'd0);

    applyStimulus(1'b0, 8'd255, 8'd255, 0);

    for (int n = 0; n < 24; n++) begin
      rDiv = 1'($urandom);
      rA   = W'($urandom);
      rB   = W'($urandom);
      if (rDiv && ($urandom_range(0, 4) == 0)) rB = '0;
      applyStimulus(rDiv, rA, rB, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multi-cycle unsigned multiply/divide sequencer that sits on the initiating side of the combinational ALU. It drives `op`/`srcA`/`srcB` into an external `alu` instance and consumes `result`/`zero`, iterating shift-add (MUL) or restoring compare/subtract (DIV) one bit per step. Requests and responses use valid/ready handshakes, so the datapath can issue MUL/DIV without a hardware multiplier or divider.

## Interface
Parameters:
- WIDTH, 8: operand width; must equal the project `word` width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_div  in  1  0 = MUL, 1 = DIV.
- req_a  in  WIDTH  multiplicand / dividend.
- req_b  in  WIDTH  multiplier / divisor.
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  consumer accepts response.
- rsp_hi  out  WIDTH  MUL: product[2W-1:W]; DIV: remainder.
- rsp_lo  out  WIDTH  MUL: product[W-1:0]; DIV: quotient.
- rsp_dbz  out  1  DIV with divisor 0.
- alu_op  out  e_alu_op  operation to ALU.
- alu_srcA  out  WIDTH  ALU operand A.
- alu_srcB  out  WIDTH  ALU operand B.
- alu_result  in  WIDTH  ALU result; combinational, sampled in the same cycle it is driven.
- alu_zero  in  1  ALU zero flag.

## Operation
- States: IDLE, MUL, DIV_CMP, DIV_SUB, DONE. Step counter is $clog2(WIDTH)+1 bits.
- IDLE:
  - `req_ready`=1. On `req_valid`, latch a, b, op and clear acc/rem.
  - MUL -> MUL.
  - DIV with b≠0 -> DIV_CMP.
  - DIV with b=0 -> DONE with lo=all-ones, hi=a, dbz=1.
- Outside MUL/DIV_CMP/DIV_SUB, ALU is driven with `ALU_NOP`, srcA=0, srcB=0.
- MUL step (WIDTH cycles):
  - Drive `ALU_ADD`, srcA=acc, srcB = lo[0] ? mcand : 0.
  - carry = (alu_result < acc), computed locally, unsigned.
  - {acc,lo} <= {carry, alu_result, lo} >> 1. Initial lo = a, acc = 0.
  - After the WIDTH-th step -> DONE with hi=acc, lo=lo.
- DIV step, MSB first, 2 cycles per bit:
  - DIV_CMP: {msb, rs} = {rem, dvd[W-1]}; dvd shifts left.
    - Drive `ALU_SLT`, srcA=b, srcB=rs.
    - ge = msb | alu_zero. Register rs and ge.
  - DIV_SUB:
    - If ge: `ALU_SUB`, srcA=rs, srcB=b; q bit = 1.
    - Else: `ALU_NOP`, srcA=rs; q bit = 0.
    - rem <= alu_result. The result is exact mod 2^W even when msb=1.
  - After WIDTH bit-pairs -> DONE with hi=rem, lo=q.
- DONE: `rsp_valid`=1. Outputs are stable until `rsp_ready`, then -> IDLE. New requests are never accepted while in DONE.

## Timing
- Reset values:
  - State IDLE; `req_ready`=1; `rsp_valid`=0.
  - `rsp_hi`=`rsp_lo`=0; `rsp_dbz`=0.
  - `alu_op`=`ALU_NOP`; `alu_srcA`=`alu_srcB`=0.
- Accept edge = cycle 0. `rsp_valid` first high at:
  - MUL: cycle WIDTH+1 (9 for W=8).
  - DIV: cycle 2·WIDTH+1 (17).
  - DIV by zero: cycle 1.
- Response handshake completes on an edge with `rsp_valid`&`rsp_ready`. `req_ready` is high the next cycle. Minimum 1 idle cycle between responses.
- `req_*` inputs are ignored outside IDLE. `rsp_*` change only on entry to DONE or reset.
- Reset mid-operation abandons the request: no response is produced, and the next cycle shows IDLE reset values.
- No combinational path from `alu_result` to `req_ready`/`rsp_*`. `alu_*` outputs depend only on registered state.

## Test plan
- MUL a=200, b=100 -> `rsp_valid` at cycle 9, hi=0x4E, lo=0x20, dbz=0. `alu_op`=`ALU_ADD` for exactly 8 cycles.
- DIV a=200, b=7 -> `rsp_valid` at cycle 17, lo=28, hi=4. `ALU_SLT`/`ALU_SUB`|`ALU_NOP` alternate.
- DIV a=250, b=130 (divisor MSB set) -> lo=1, hi=120. DIV a=5, b=9 -> lo=0, hi=5.
- DIV a=55, b=0 -> `rsp_valid` at cycle 1, lo=0xFF, hi=55, dbz=1. `alu_op` stays `ALU_NOP`.
- Backpressure: MUL 15×17 with `rsp_ready`=0 for 5 cycles after `rsp_valid`:
  - hi=0x00, lo=0xFF held stable.
  - `req_ready`=0, and a pulsed `req_valid` is ignored.
  - After `rsp_ready` goes high, `req_ready`=1 the next cycle.
- Reset at cycle 4 of a MUL -> next cycle `rsp_valid`=0, `req_ready`=1, `alu_op`=`ALU_NOP`. Then MUL 255×255 -> hi=0xFE, lo=0x01 at cycle 9.
